// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four requesters feeding one shared 4:1 select datapath.
// A grant is held for up to BURST_LEN accepted beats; every release is followed by one IDLE cycle.
module rr_mux4_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       beat_q, beat_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] mux_data;
  logic             owner_req;
  logic             xfer;

  // Scan from ptr upward; iterating high-to-low offset lets the nearest hit win.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_data = din0;
      2'd1:    mux_data = din1;
      2'd2:    mux_data = din2;
      default: mux_data = din3;
    endcase
  end

  assign owner_req = req[sel_q];
  assign busy      = (state_q == S_GRANT);
  assign out_valid = busy && owner_req;
  assign out_data  = out_valid ? mux_data : '0;
  assign xfer      = out_valid && out_ready;
  assign grant     = grant_q;
  assign sel       = sel_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          beat_d  = '0;
        end
      end
      S_GRANT: begin
        if (xfer) beat_d = beat_q + 4'd1;
        // A dropped request and a final beat on the same edge are one release.
        if (!owner_req || (xfer && beat_q == LAST_BEAT)) begin
          state_d = S_IDLE;
          grant_d = '0;
          beat_d  = '0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: BURST_LEN=4 and BURST_LEN=1 instances share stimulus and are
// compared every cycle against a transaction-level round-robin model, plus directed vectors.
module tb_rr_mux4_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [W-1:0] din [4];
  logic         out_ready = 1'b0;

  logic         valid_w [2];
  logic [W-1:0] data_w  [2];
  logic [3:0]   grant_w [2];
  logic [1:0]   sel_w   [2];
  logic         busy_w  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.WIDTH(W), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .out_ready(out_ready), .out_valid(valid_w[0]), .out_data(data_w[0]),
    .grant(grant_w[0]), .sel(sel_w[0]), .busy(busy_w[0])
  );

  rr_mux4_arbiter #(.WIDTH(W), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .out_ready(out_ready), .out_valid(valid_w[1]), .out_data(data_w[1]),
    .grant(grant_w[1]), .sel(sel_w[1]), .busy(busy_w[1])
  );

  // Reference model: owner = -1 when idle, otherwise the source index holding the grant.
  typedef struct {
    int owner;
    int last_sel;
    int beats;
    int ptr;
  } model_t;

  model_t    ms [2];
  const int  burst [2] = '{4, 1};

  // Values the bench captured for dut4 in the most recent cycle, for table checks.
  logic [3:0]   cap_grant;
  logic [1:0]   cap_sel;
  logic         cap_valid;
  logic         cap_busy;
  logic [W-1:0] cap_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) ms[d] = '{owner: -1, last_sel: 0, beats: 0, ptr: 0};
  endtask

  // Enter at a negedge: drive, compare both DUTs to the model, advance the model over the posedge.
  task automatic step(input logic [3:0] r, input logic rd);
    req = r;
    out_ready = rd;
    #1;
    for (int d = 0; d < 2; d++) begin
      bit            m_busy  = (ms[d].owner >= 0);
      bit            m_valid = m_busy && r[ms[d].owner];
      logic [3:0]    m_grant = m_busy ? 4'(1 << ms[d].owner) : 4'd0;
      logic [W-1:0]  m_data  = m_valid ? din[ms[d].owner] : '0;
      check($sformatf("d%0d_grant", d), 32'(grant_w[d]), 32'(m_grant));
      check($sformatf("d%0d_sel", d),   32'(sel_w[d]),   32'(ms[d].last_sel));
      check($sformatf("d%0d_busy", d),  32'(busy_w[d]),  32'(m_busy));
      check($sformatf("d%0d_valid", d), 32'(valid_w[d]), 32'(m_valid));
      check($sformatf("d%0d_data", d),  32'(data_w[d]),  32'(m_data));
    end
    cap_grant = grant_w[0];
    cap_sel   = sel_w[0];
    cap_valid = valid_w[0];
    cap_busy  = busy_w[0];
    cap_data  = data_w[0];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ms[d].owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          int i = (ms[d].ptr + k) % 4;
          if (r[i]) begin
            ms[d].owner = i;
            ms[d].last_sel = i;
            ms[d].beats = 0;
            break;
          end
        end
      end else begin
        int  o    = ms[d].owner;
        bit  xfer = r[o] && rd;
        if (xfer) ms[d].beats++;
        if (!r[o] || (xfer && ms[d].beats == burst[d])) begin
          ms[d].ptr   = (o + 1) % 4;
          ms[d].owner = -1;
          ms[d].beats = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Assert reset away from any clock edge and check outputs clear without an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_d%0d_grant", d), 32'(grant_w[d]), 32'd0);
      check($sformatf("rst_d%0d_sel", d),   32'(sel_w[d]),   32'd0);
      check($sformatf("rst_d%0d_valid", d), 32'(valid_w[d]), 32'd0);
      check($sformatf("rst_d%0d_busy", d),  32'(busy_w[d]),  32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   req;
    logic         ready;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         valid;
    logic         busy;
    logic [W-1:0] data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'(8'h10 * (i + 1));
    din[2] = 8'hA5;
    model_reset();

    // Single requester src2: 4 beats, one IDLE bubble, re-grant, then drop.
    vecs[0] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
    vecs[3] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
    vecs[4] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
    vecs[5] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
    vecs[7] = '{4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'h00};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00};

    @(negedge clk);
    do_reset();

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].req, vecs[v].ready);
      check($sformatf("vec%0d_grant", v), 32'(cap_grant), 32'(vecs[v].grant));
      check($sformatf("vec%0d_sel", v),   32'(cap_sel),   32'(vecs[v].sel));
      check($sformatf("vec%0d_valid", v), 32'(cap_valid), 32'(vecs[v].valid));
      check($sformatf("vec%0d_busy", v),  32'(cap_busy),  32'(vecs[v].busy));
      check($sformatf("vec%0d_data", v),  32'(cap_data),  32'(vecs[v].data));
    end

    // Owner src3 drops after 2 beats while src0 waits: ptr wraps to 0, src0 next.
    do_reset();
    step(4'b1000, 1'b1);
    step(4'b1001, 1'b1);
    check("drop_owner3", 32'(cap_grant), 32'h8);
    step(4'b1001, 1'b1);
    step(4'b0001, 1'b1);
    check("drop_valid0", 32'(cap_valid), 32'd0);
    step(4'b0001, 1'b1);
    check("drop_bubble", 32'(cap_busy), 32'd0);
    step(4'b0001, 1'b1);
    check("drop_next0", 32'(cap_grant), 32'h1);

    // Backpressure on src1: owner and data hold while out_ready is low.
    do_reset();
    din[1] = 8'h3C;
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
    check("bp_valid", 32'(cap_valid), 32'd1);
    check("bp_data", 32'(cap_data), 32'h3C);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1);
    check("bp_last_beat", 32'(cap_grant), 32'h2);
    step(4'b0010, 1'b1);
    check("bp_released", 32'(cap_busy), 32'd0);

    // Reset mid-burst, then req=1010 must grant src1 first.
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);
    do_reset();
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    check("post_rst_grant", 32'(cap_grant), 32'h2);

    // All requesting: rotation 0,1,2,3 on the BURST_LEN=4 instance.
    do_reset();
    for (int i = 0; i < 22; i++) step(4'b1111, 1'b1);

    // Randomized traffic; requests are sticky so bursts run to completion often.
    do_reset();
    begin
      logic [3:0] r = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        if (c == 1500) do_reset();
        step(r, $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
